// File: rtl/bin2gray_pkg.sv
// Shared defaults and types for the bin2gray arbiter slice: code width,
// requester count, in-flight limit and the requester tag used by the tag FIFO.
package bin2gray_pkg;

   localparam int CODE_WIDTH_DEF      = 4;
   localparam int NUM_REQ_DEF         = 4;
   localparam int MAX_OUTSTANDING_DEF = 4;
   localparam int TAG_WIDTH_DEF       = $clog2(NUM_REQ_DEF);

   typedef logic [CODE_WIDTH_DEF-1:0] code_t;
   typedef logic [TAG_WIDTH_DEF-1:0]  tag_t;

endpackage

// File: rtl/bin2gray_arbiter_if.sv
// Bundle of requester handshakes and converter-side signals around the arbiter.
// The arbiter uses the slave view; clients and the converter use the master view.
interface bin2gray_arbiter_if
   import bin2gray_pkg::*;
#(
   parameter int CODE_WIDTH = CODE_WIDTH_DEF,
   parameter int NUM_REQ    = NUM_REQ_DEF
) ();

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*CODE_WIDTH-1:0] req_code;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [CODE_WIDTH-1:0]         rsp_code;
   logic [CODE_WIDTH-1:0]         cnv_binary_code;
   logic                          cnv_binary_code_valid;
   logic [CODE_WIDTH-1:0]         cnv_gray_code;
   logic                          cnv_gray_code_valid;

   modport master (
      output req_valid,
      output req_code,
      output cnv_gray_code,
      output cnv_gray_code_valid,
      input  req_ready,
      input  rsp_valid,
      input  rsp_code,
      input  cnv_binary_code,
      input  cnv_binary_code_valid
   );

   modport slave (
      input  req_valid,
      input  req_code,
      input  cnv_gray_code,
      input  cnv_gray_code_valid,
      output req_ready,
      output rsp_valid,
      output rsp_code,
      output cnv_binary_code,
      output cnv_binary_code_valid
   );

endinterface

// File: rtl/bin2gray_tag_fifo.sv
// In-order FIFO of requester tags, one entry per conversion in flight.
// Pointers carry one extra MSB so full and empty are told apart without a counter.
module bin2gray_tag_fifo
   import bin2gray_pkg::*;
#(
   parameter int DEPTH = MAX_OUTSTANDING_DEF,
   parameter int WIDTH = $bits(tag_t)
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_tag,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_tag,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count    = wr_ptr - rd_ptr;
   assign head_tag = mem[rd_ptr[AW-1:0]];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

   // Storage has no reset; an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_tag;
      end
   end

endmodule

// File: rtl/bin2gray_arbiter.sv
// Round-robin front end sharing one bin2gray converter among several requesters;
// a tag FIFO remembers who owns each in-flight conversion so results route home.
module bin2gray_arbiter
   import bin2gray_pkg::*;
#(
   parameter int CODE_WIDTH      = CODE_WIDTH_DEF,
   parameter int NUM_REQ         = NUM_REQ_DEF,
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
   input  logic                             clk,
   input  logic                             rstn,
   bin2gray_arbiter_if.slave                bus,
   output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
   output logic                             err_orphan
);

   localparam int TAG_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [TAG_WIDTH-1:0]  rr_ptr;
   logic [TAG_WIDTH-1:0]  next_ptr;
   logic [TAG_WIDTH-1:0]  grant_idx;
   logic [TAG_WIDTH-1:0]  head_tag;
   logic [TAG_WIDTH:0]    cand;
   logic                  grant_found;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_REQ-1:0]    rsp_onehot;
   logic [CODE_WIDTH-1:0] grant_code;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  pop;
   logic [CODE_WIDTH-1:0] cnv_code_q;
   logic                  cnv_valid_q;
   logic [NUM_REQ-1:0]    rsp_valid_q;
   logic [CODE_WIDTH-1:0] rsp_code_q;

   // Search from rr_ptr upward with wrap; a full FIFO blocks every grant, even
   // when a pop lands in the same cycle.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      if (rstn && !fifo_full) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (TAG_WIDTH+1)'(k);
            if (cand >= (TAG_WIDTH+1)'(NUM_REQ)) begin
               cand = cand - (TAG_WIDTH+1)'(NUM_REQ);
            end
            if (!grant_found && bus.req_valid[cand[TAG_WIDTH-1:0]]) begin
               grant_found = 1'b1;
               grant_idx   = cand[TAG_WIDTH-1:0];
            end
         end
      end
   end

   always_comb begin
      grant = '0;
      if (grant_found) begin
         grant[grant_idx] = 1'b1;
      end
      rsp_onehot = '0;
      rsp_onehot[head_tag] = 1'b1;
      next_ptr = (grant_idx == TAG_WIDTH'(NUM_REQ-1)) ? '0 : grant_idx + TAG_WIDTH'(1);
      grant_code = bus.req_code[int'(grant_idx)*CODE_WIDTH +: CODE_WIDTH];
   end

   assign pop = bus.cnv_gray_code_valid && !fifo_empty;

   bin2gray_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (TAG_WIDTH)
   ) u_tag_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .push     (grant_found),
      .push_tag (grant_idx),
      .pop      (pop),
      .head_tag (head_tag),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (outstanding)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr      <= '0;
         cnv_code_q  <= '0;
         cnv_valid_q <= 1'b0;
      end else begin
         cnv_valid_q <= grant_found;
         if (grant_found) begin
            rr_ptr     <= next_ptr;
            cnv_code_q <= grant_code;
         end
      end
   end

   // A converter result with no tag pending is dropped and latched as an error.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp_valid_q <= '0;
         rsp_code_q  <= '0;
         err_orphan  <= 1'b0;
      end else begin
         rsp_valid_q <= pop ? rsp_onehot : '0;
         if (pop) begin
            rsp_code_q <= bus.cnv_gray_code;
         end
         if (bus.cnv_gray_code_valid && fifo_empty) begin
            err_orphan <= 1'b1;
         end
      end
   end

   assign bus.req_ready             = grant;
   assign bus.cnv_binary_code       = cnv_code_q;
   assign bus.cnv_binary_code_valid = cnv_valid_q;
   assign bus.rsp_valid             = rsp_valid_q;
   assign bus.rsp_code              = rsp_code_q;

endmodule

// File: tb/tb_bin2gray_arbiter.sv
// Directed bench for bin2gray_arbiter: a vector table for round robin, single
// request and pointer wrap, then hand sequences for orphan, reset and full stall.
module tb_bin2gray_arbiter;
   import bin2gray_pkg::*;

   logic clk = 1'b0;
   logic rstn;

   always #5 clk = ~clk;

   bin2gray_arbiter_if #(.CODE_WIDTH(4), .NUM_REQ(4)) bus ();
   bin2gray_arbiter_if #(.CODE_WIDTH(4), .NUM_REQ(4)) bus_s ();

   logic [2:0] outstanding;
   logic       err_orphan;
   logic [1:0] outstanding_s;
   logic       err_orphan_s;

   bin2gray_arbiter #(.CODE_WIDTH(4), .NUM_REQ(4), .MAX_OUTSTANDING(4)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .bus         (bus),
      .outstanding (outstanding),
      .err_orphan  (err_orphan)
   );

   bin2gray_arbiter #(.CODE_WIDTH(4), .NUM_REQ(4), .MAX_OUTSTANDING(2)) dut_s (
      .clk         (clk),
      .rstn        (rstn),
      .bus         (bus_s),
      .outstanding (outstanding_s),
      .err_orphan  (err_orphan_s)
   );

   // Registered converter (L=1) for the main instance, with mute and injection hooks.
   logic [3:0] g_code;
   logic       g_valid;
   logic       cnv_mute;
   logic       inject_valid;
   logic [3:0] inject_code;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         g_code  <= '0;
         g_valid <= 1'b0;
      end else begin
         g_valid <= bus.cnv_binary_code_valid;
         g_code  <= bus.cnv_binary_code ^ (bus.cnv_binary_code >> 1);
      end
   end

   assign bus.cnv_gray_code_valid = (g_valid & ~cnv_mute) | inject_valid;
   assign bus.cnv_gray_code       = inject_valid ? inject_code : g_code;

   // Slow converter (L=4) for the stall instance.
   logic [3:0] s_vpipe;
   logic [3:0] s_c0, s_c1, s_c2, s_c3;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s_vpipe <= '0;
         s_c0 <= '0;
         s_c1 <= '0;
         s_c2 <= '0;
         s_c3 <= '0;
      end else begin
         s_vpipe <= {s_vpipe[2:0], bus_s.cnv_binary_code_valid};
         s_c0 <= bus_s.cnv_binary_code ^ (bus_s.cnv_binary_code >> 1);
         s_c1 <= s_c0;
         s_c2 <= s_c1;
         s_c3 <= s_c2;
      end
   end

   assign bus_s.cnv_gray_code_valid = s_vpipe[3];
   assign bus_s.cnv_gray_code       = s_c3;

   typedef struct {
      logic [3:0]  valid;
      logic [15:0] code;
      logic [3:0]  ready;
      logic        cnv_v;
      logic [3:0]  cnv_code;
      logic [3:0]  rsp_v;
      logic [3:0]  rsp_code;
      logic [2:0]  outst;
   } vec_t;

   localparam int NUM_VECS = 24;
   vec_t vecs [NUM_VECS];

   int checks;
   int failures;

   function automatic vec_t mk(logic [3:0] v, logic [15:0] c, logic [3:0] rdy, logic cv,
                               logic [3:0] cc, logic [3:0] rv, logic [3:0] rc, logic [2:0] o);
      vec_t r;
      r.valid    = v;
      r.code     = c;
      r.ready    = rdy;
      r.cnv_v    = cv;
      r.cnv_code = cc;
      r.rsp_v    = rv;
      r.rsp_code = rc;
      r.outst    = o;
      return r;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [3:0] valid, input logic [15:0] code);
      bus.req_valid = valid;
      bus.req_code  = code;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_main_idle(input string tag);
      check_output({tag, " req_ready"}, 32'(bus.req_ready), 32'h0);
      check_output({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
      check_output({tag, " rsp_code"}, 32'(bus.rsp_code), 32'h0);
      check_output({tag, " cnv_code"}, 32'(bus.cnv_binary_code), 32'h0);
      check_output({tag, " cnv_valid"}, 32'(bus.cnv_binary_code_valid), 32'h0);
      check_output({tag, " outstanding"}, 32'(outstanding), 32'h0);
      check_output({tag, " err_orphan"}, 32'(err_orphan), 32'h0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      checks       = 0;
      failures     = 0;
      rstn         = 1'b0;
      cnv_mute     = 1'b0;
      inject_valid = 1'b0;
      inject_code  = '0;
      apply_stimulus(4'h0, 16'h0000);
      bus_s.req_valid = '0;
      bus_s.req_code  = '0;

      // Codes 3,6,7,8 on requesters 0..3 give Gray 2,5,4,C.
      vecs[0]  = mk(4'hF, 16'h8763, 4'h1, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0);
      vecs[1]  = mk(4'hF, 16'h8763, 4'h2, 1'b1, 4'h3, 4'h0, 4'h0, 3'd1);
      vecs[2]  = mk(4'hF, 16'h8763, 4'h4, 1'b1, 4'h6, 4'h0, 4'h0, 3'd2);
      vecs[3]  = mk(4'hF, 16'h8763, 4'h8, 1'b1, 4'h7, 4'h1, 4'h2, 3'd2);
      vecs[4]  = mk(4'hF, 16'h8763, 4'h1, 1'b1, 4'h8, 4'h2, 4'h5, 3'd2);
      vecs[5]  = mk(4'hF, 16'h8763, 4'h2, 1'b1, 4'h3, 4'h4, 4'h4, 3'd2);
      vecs[6]  = mk(4'hF, 16'h8763, 4'h4, 1'b1, 4'h6, 4'h8, 4'hC, 3'd2);
      vecs[7]  = mk(4'hF, 16'h8763, 4'h8, 1'b1, 4'h7, 4'h1, 4'h2, 3'd2);
      vecs[8]  = mk(4'h0, 16'h0000, 4'h0, 1'b1, 4'h8, 4'h2, 4'h5, 3'd2);
      vecs[9]  = mk(4'h0, 16'h0000, 4'h0, 1'b0, 4'h8, 4'h4, 4'h4, 3'd1);
      vecs[10] = mk(4'h0, 16'h0000, 4'h0, 1'b0, 4'h8, 4'h8, 4'hC, 3'd0);
      vecs[11] = mk(4'h0, 16'h0000, 4'h0, 1'b0, 4'h8, 4'h0, 4'hC, 3'd0);
      vecs[12] = mk(4'h4, 16'h0500, 4'h4, 1'b0, 4'h8, 4'h0, 4'hC, 3'd0);
      vecs[13] = mk(4'h0, 16'h0000, 4'h0, 1'b1, 4'h5, 4'h0, 4'hC, 3'd1);
      vecs[14] = mk(4'h0, 16'h0000, 4'h0, 1'b0, 4'h5, 4'h0, 4'hC, 3'd1);
      vecs[15] = mk(4'h0, 16'h0000, 4'h0, 1'b0, 4'h5, 4'h4, 4'h7, 3'd0);
      vecs[16] = mk(4'h0, 16'h0000, 4'h0, 1'b0, 4'h5, 4'h0, 4'h7, 3'd0);
      vecs[17] = mk(4'h8, 16'h9000, 4'h8, 1'b0, 4'h5, 4'h0, 4'h7, 3'd0);
      vecs[18] = mk(4'h9, 16'hA001, 4'h1, 1'b1, 4'h9, 4'h0, 4'h7, 3'd1);
      vecs[19] = mk(4'h8, 16'hA000, 4'h8, 1'b1, 4'h1, 4'h0, 4'h7, 3'd2);
      vecs[20] = mk(4'h0, 16'h0000, 4'h0, 1'b1, 4'hA, 4'h8, 4'hD, 3'd2);
      vecs[21] = mk(4'h0, 16'h0000, 4'h0, 1'b0, 4'hA, 4'h1, 4'h1, 3'd1);
      vecs[22] = mk(4'h0, 16'h0000, 4'h0, 1'b0, 4'hA, 4'h8, 4'hF, 3'd0);
      vecs[23] = mk(4'h0, 16'h0000, 4'h0, 1'b0, 4'hA, 4'h0, 4'hF, 3'd0);

      repeat (3) @(posedge clk);
      #1;
      check_main_idle("reset");
      check_output("reset stall outstanding", 32'(outstanding_s), 32'h0);
      check_output("reset stall err_orphan", 32'(err_orphan_s), 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      next_cycle();

      for (int i = 0; i < NUM_VECS; i++) begin
         apply_stimulus(vecs[i].valid, vecs[i].code);
         #1;
         check_output($sformatf("vec%0d req_ready", i), 32'(bus.req_ready), 32'(vecs[i].ready));
         check_output($sformatf("vec%0d cnv_valid", i), 32'(bus.cnv_binary_code_valid), 32'(vecs[i].cnv_v));
         check_output($sformatf("vec%0d cnv_code", i), 32'(bus.cnv_binary_code), 32'(vecs[i].cnv_code));
         check_output($sformatf("vec%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].rsp_v));
         check_output($sformatf("vec%0d rsp_code", i), 32'(bus.rsp_code), 32'(vecs[i].rsp_code));
         check_output($sformatf("vec%0d outstanding", i), 32'(outstanding), 32'(vecs[i].outst));
         check_output($sformatf("vec%0d err_orphan", i), 32'(err_orphan), 32'h0);
         next_cycle();
      end

      inject_code  = 4'h6;
      inject_valid = 1'b1;
      next_cycle();
      inject_valid = 1'b0;
      #1;
      check_output("orphan err_orphan", 32'(err_orphan), 32'h1);
      check_output("orphan rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check_output("orphan rsp_code held", 32'(bus.rsp_code), 32'hF);
      check_output("orphan outstanding", 32'(outstanding), 32'h0);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         check_output($sformatf("orphan sticky%0d", i), 32'(err_orphan), 32'h1);
         check_output($sformatf("orphan no rsp%0d", i), 32'(bus.rsp_valid), 32'h0);
      end

      // Results are muted so three conversions stay in flight when reset hits.
      cnv_mute = 1'b1;
      apply_stimulus(4'b0111, 16'h0321);
      #1;
      check_output("flight grant0", 32'(bus.req_ready), 32'h1);
      next_cycle();
      apply_stimulus(4'b0110, 16'h0321);
      #1;
      check_output("flight grant1", 32'(bus.req_ready), 32'h2);
      next_cycle();
      apply_stimulus(4'b0100, 16'h0321);
      #1;
      check_output("flight grant2", 32'(bus.req_ready), 32'h4);
      next_cycle();
      apply_stimulus(4'b0000, 16'h0000);
      #1;
      check_output("flight outstanding", 32'(outstanding), 32'h3);
      rstn = 1'b0;
      #1;
      check_main_idle("midreset");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rstn     = 1'b1;
      cnv_mute = 1'b0;
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         check_output($sformatf("postreset rsp_valid%0d", i), 32'(bus.rsp_valid), 32'h0);
         check_output($sformatf("postreset outstanding%0d", i), 32'(outstanding), 32'h0);
      end
      apply_stimulus(4'b0010, 16'h00F0);
      #1;
      check_output("postreset grant", 32'(bus.req_ready), 32'h2);
      next_cycle();
      apply_stimulus(4'b0000, 16'h0000);
      #1;
      check_output("postreset cnv_valid", 32'(bus.cnv_binary_code_valid), 32'h1);
      check_output("postreset cnv_code", 32'(bus.cnv_binary_code), 32'hF);
      next_cycle();
      next_cycle();
      check_output("postreset rsp_valid", 32'(bus.rsp_valid), 32'h2);
      check_output("postreset rsp_code", 32'(bus.rsp_code), 32'h8);

      // Stall instance: depth 2, converter latency 4.
      bus_s.req_valid = 4'b0011;
      bus_s.req_code  = 16'h0042;
      #1;
      check_output("stall s0 ready", 32'(bus_s.req_ready), 32'h1);
      check_output("stall s0 outstanding", 32'(outstanding_s), 32'h0);
      next_cycle();
      check_output("stall s1 ready", 32'(bus_s.req_ready), 32'h2);
      check_output("stall s1 outstanding", 32'(outstanding_s), 32'h1);
      next_cycle();
      bus_s.req_valid = 4'b0001;
      #1;
      for (int s = 2; s <= 5; s++) begin
         check_output($sformatf("stall s%0d ready", s), 32'(bus_s.req_ready), 32'h0);
         check_output($sformatf("stall s%0d outstanding", s), 32'(outstanding_s), 32'h2);
         next_cycle();
      end
      check_output("stall s6 ready", 32'(bus_s.req_ready), 32'h1);
      check_output("stall s6 outstanding", 32'(outstanding_s), 32'h1);
      check_output("stall s6 rsp_valid", 32'(bus_s.rsp_valid), 32'h1);
      check_output("stall s6 rsp_code", 32'(bus_s.rsp_code), 32'h3);
      next_cycle();
      bus_s.req_valid = 4'b0000;
      bus_s.req_code  = 16'h0000;
      #1;
      check_output("stall s7 rsp_valid", 32'(bus_s.rsp_valid), 32'h2);
      check_output("stall s7 rsp_code", 32'(bus_s.rsp_code), 32'h6);
      check_output("stall s7 outstanding", 32'(outstanding_s), 32'h1);
      repeat (4) next_cycle();
      check_output("stall s11 rsp_valid", 32'(bus_s.rsp_valid), 32'h0);
      check_output("stall s11 outstanding", 32'(outstanding_s), 32'h1);
      next_cycle();
      check_output("stall s12 rsp_valid", 32'(bus_s.rsp_valid), 32'h1);
      check_output("stall s12 rsp_code", 32'(bus_s.rsp_code), 32'h3);
      check_output("stall s12 outstanding", 32'(outstanding_s), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bin2gray_arbiter.md
# bin2gray_arbiter

Round-robin arbiter that shares one `bin2gray` converter among `NUM_REQ` requesters. It accepts binary codes over per-requester valid/ready handshakes and drives them into the converter one per cycle. An in-order tag FIFO tracks which requester owns each in-flight conversion, so each Gray result is routed back to its originator. The block sits between the requester clients and the single `bin2gray` instance, which shares the same `clk`/`rstn`.

## Interface
- `CODE_WIDTH`, 4, binary/Gray code width
- `NUM_REQ`, 4, number of requesters (2..16)
- `MAX_OUTSTANDING`, 4, in-flight conversion limit; tag FIFO depth (power of 2)

- `clk`  input  1  clock
- `rstn`  input  1  reset; one clock; reset is asynchronous and active-low
- `req_valid`  input  NUM_REQ  per-requester request valid
- `req_code`  input  NUM_REQ*CODE_WIDTH  binary codes; requester i at bits [i*CODE_WIDTH +: CODE_WIDTH]
- `req_ready`  output  NUM_REQ  grant; one-hot or zero
- `rsp_valid`  output  NUM_REQ  one-cycle result strobe to the owning requester; one-hot or zero
- `rsp_code`  output  CODE_WIDTH  Gray result, broadcast to all requesters, qualified by `rsp_valid`
- `cnv_binary_code`  output  CODE_WIDTH  to converter `binary_code`
- `cnv_binary_code_valid`  output  1  to converter `binary_code_valid`
- `cnv_gray_code`  input  CODE_WIDTH  from converter `gray_code`
- `cnv_gray_code_valid`  input  1  from converter `gray_code_valid`
- `outstanding`  output  $clog2(MAX_OUTSTANDING)+1  number of in-flight conversions
- `err_orphan`  output  1  sticky flag: converter result arrived with no tag pending

## Operation
- **Transfer:** a request transfers when `req_valid[i] && req_ready[i]`.
  - `req_ready` is combinational from `req_valid`, the round-robin pointer and FIFO full.
  - Requesters must hold `req_valid` and `req_code` until the transfer.
- **Arbitration:** round-robin with pointer `rr_ptr`.
  - Search starts at `rr_ptr` and wraps modulo `NUM_REQ`; the first valid requester is granted.
  - After a grant to requester g, `rr_ptr` becomes (g+1) mod `NUM_REQ`.
  - With no grant, `rr_ptr` holds.
- **Full:** no grant while the tag FIFO is full (`outstanding == MAX_OUTSTANDING`). This applies even when a pop occurs in the same cycle.
- **Dispatch:** on transfer, the selected code is registered into `cnv_binary_code` and `cnv_binary_code_valid` is asserted for exactly one cycle. The index g is pushed into the tag FIFO.
- **Return:**
  - On `cnv_gray_code_valid`, the head tag t is popped.
  - The next cycle, `rsp_valid[t]` = 1 and `rsp_code` = `cnv_gray_code`, both registered.
  - Results return in issue order; the converter is fixed-latency and never reorders.
- **Simultaneous push and pop** in the same cycle (FIFO not full): both occur and `outstanding` is unchanged.
- **No backpressure on responses:** requesters must accept `rsp_valid` unconditionally.
- **Orphan result:** `cnv_gray_code_valid` while the FIFO is empty is dropped. No `rsp_valid` is raised and `err_orphan` is set; it clears only on reset.
- **Idle outputs:** `rsp_code` holds its last value when `rsp_valid` = 0. `cnv_binary_code` holds when `cnv_binary_code_valid` = 0.

## Timing
- **Reset values:** `req_ready` 0, `rsp_valid` 0, `rsp_code` 0, `cnv_binary_code` 0, `cnv_binary_code_valid` 0, `outstanding` 0, `err_orphan` 0, `rr_ptr` 0, FIFO empty.
- **Latency:**
  - Handshake at cycle T.
  - `cnv_binary_code_valid` at T+1.
  - Converter result at T+1+L.
  - `rsp_valid` at T+2+L.
  - With the registered `bin2gray` (L=1), the response is at T+3.
- **Throughput:** one request per cycle sustained when L+1 < `MAX_OUTSTANDING`.
- **Reset mid-operation:** all in-flight tags are discarded and no `rsp_valid` is issued for them. The converter shares `rstn`, so no stale results follow.

## Structure
- **Package `bin2gray_pkg`:**
  - `CODE_WIDTH` default
  - `code_t` typedef
  - `tag_t` typedef (width $clog2(NUM_REQ), default 4 requesters)
- **Sub-module `bin2gray_tag_fifo`:**
  - Synchronous FIFO of `tag_t`, depth `MAX_OUTSTANDING`, with push/pop/full/empty/count.
  - Wrap-around pointers carry an extra MSB to distinguish full from empty.
- **Top level:** arbiter logic, dispatch register and response register.

## Test plan
- **Single request:** req 2 sends 5 -> `cnv_binary_code` = 5 at T+1; `rsp_valid` = 0100, `rsp_code` = 7 at T+3.
- **Round robin:** all 4 requesters valid continuously with codes 3, 6, 7, 8 -> grants in order 0,1,2,3,0. Responses 2, 5, 4, 12 arrive on `rsp_valid` 0001, 0010, 0100, 1000 on consecutive cycles.
- **Full stall:** `MAX_OUTSTANDING` = 2, converter valid delayed by 4 cycles.
  - `req_ready` drops after 2 grants with `outstanding` = 2.
  - The third grant occurs only the cycle after the first pop.
- **Wrap pointer:** last grant to req 3, then req 0 and req 3 both valid -> req 0 granted.
- **Orphan:** inject `cnv_gray_code_valid` with the FIFO empty -> `err_orphan` = 1, no `rsp_valid`, flag held until `rstn`.
- **Reset mid-flight:** assert `rstn` = 0 with 3 outstanding -> all outputs at reset values, `outstanding` = 0, no responses after release. The next request, 15, returns 8.
